// File: rtl/sap_ram_loader.sv
// Program loader for the SAP RAM: takes a byte stream over valid/ready and writes it
// to consecutive RAM addresses from 0, holding the CPU off the bus while it does so.
module sap_ram_loader #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {IDLE, WAIT, WRITE, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [ADDR_W:0]     len_reg;
  logic [ADDR_W:0]     count_reg;
  logic [ADDR_W-1:0]   ram_addr_reg;
  logic [DATA_W-1:0]   ram_data_reg;
  logic [ADDR_W:0]     len_clamped;
  logic [ADDR_W:0]     count_inc;

  // Clamping to the RAM depth guarantees the address never wraps inside a load.
  assign len_clamped = (len > DEPTH) ? DEPTH : len;
  assign count_inc   = count_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      len_reg      <= '0;
      count_reg    <= '0;
      ram_addr_reg <= '0;
      ram_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            len_reg   <= len_clamped;
            addr_reg  <= '0;
            count_reg <= '0;
          end
        end
        WAIT: begin
          // The write port registers double as the captured byte, so they hold between writes.
          if (in_valid) begin
            ram_addr_reg <= addr_reg;
            ram_data_reg <= in_data;
          end
        end
        WRITE: begin
          addr_reg  <= addr_reg + 1'b1;
          count_reg <= count_inc;
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (len_clamped == '0) ? DONE : WAIT;
      WAIT:    if (in_valid) state_next = WRITE;
      WRITE:   state_next = (count_inc == len_reg) ? DONE : WAIT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = 1'b0;
    ram_we   = 1'b0;
    done     = 1'b0;
    busy     = 1'b1;
    case (state_reg)
      IDLE:    busy     = 1'b0;
      WAIT:    in_ready = 1'b1;
      WRITE:   ram_we   = 1'b1;
      DONE:    done     = 1'b1;
      default: busy     = 1'b0;
    endcase
  end

  assign cpu_hold = busy;
  assign ram_addr = ram_addr_reg;
  assign ram_data = ram_data_reg;
  assign count    = count_reg;

endmodule

// File: tb/tb_sap_ram_loader.sv
// Bench for sap_ram_loader: table of loads checked against a write scoreboard,
// plus hand-written reset, ignored-start and idle-valid sequences.
module tb_sap_ram_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [4:0] len;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic       ram_we;
  logic       cpu_hold;
  logic       busy;
  logic       done;
  logic [4:0] count;

  sap_ram_loader #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         len;
    int         gap;
    logic [7:0] base;
    bit         pat;
    int         exp_writes;
    int         exp_count;
    int         exp_done;
  } vec_t;

  typedef struct {
    logic [3:0] a;
    logic [7:0] d;
  } wr_t;

  vec_t vecs[6];
  wr_t  sb_q[$];
  logic [7:0] mem [16];
  int tests_run = 0;
  int tests_failed = 0;
  int acc_total = 0;
  int acc_base = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] exp_byte(input int e, input int i);
    if (vecs[e].pat && i == 0) return 8'hA5;
    if (vecs[e].pat && i == 1) return 8'h5A;
    if (vecs[e].pat && i == 2) return 8'hFF;
    return vecs[e].base + 8'(i);
  endfunction

  // Scoreboard producer: each accepted byte must be written to the next address.
  always @(posedge clk) begin
    if (reset === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1) begin
      sb_q.push_back('{a: 4'(acc_total - acc_base), d: in_data});
      acc_total++;
    end
  end

  always @(negedge clk) begin
    if (ram_we === 1'b1) begin
      wr_cnt++;
      if (sb_q.size() == 0) begin
        chk("unexpected_write", int'(ram_addr), -1);
      end else begin
        wr_t w;
        w = sb_q.pop_front();
        chk("write_addr", int'(ram_addr), int'(w.a));
        chk("write_data", int'(ram_data), int'(w.d));
      end
      mem[ram_addr] = ram_data;
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic run_load(input int e);
    int t, since, prev, w0, d0, leff;
    w0 = wr_cnt;
    d0 = done_cnt;
    leff = (vecs[e].len > 16) ? 16 : vecs[e].len;
    acc_base = acc_total;
    len = 5'(vecs[e].len);
    start = 1'b1;
    in_valid = 1'b0;
    tick();
    start = 1'b0;
    chk($sformatf("v%0d_hold_n1", e), int'(cpu_hold), 1);
    chk($sformatf("v%0d_busy_n1", e), int'(busy), 1);
    chk($sformatf("v%0d_ready_n1", e), int'(in_ready), (leff > 0) ? 1 : 0);
    t = 1;
    since = 99;
    prev = acc_total;
    while (done !== 1'b1 && t < 400) begin
      if (acc_total != prev) begin
        since = 1;
        prev = acc_total;
      end else begin
        since++;
      end
      if (vecs[e].gap > 0 && since == 1)
        chk($sformatf("v%0d_ready_in_write", e), int'(in_ready), 0);
      if (vecs[e].gap > 0 && since >= 2 && since < 99)
        chk($sformatf("v%0d_ready_waiting", e), int'(in_ready), 1);
      in_data = exp_byte(e, acc_total - acc_base);
      in_valid = (since > vecs[e].gap);
      tick();
      t++;
    end
    in_valid = 1'b0;
    chk($sformatf("v%0d_done_cycle", e), t, vecs[e].exp_done);
    chk($sformatf("v%0d_count", e), int'(count), vecs[e].exp_count);
    tick();
    chk($sformatf("v%0d_hold_after", e), int'(cpu_hold), 0);
    chk($sformatf("v%0d_done_pulse", e), int'(done), 0);
    chk($sformatf("v%0d_writes", e), wr_cnt - w0, vecs[e].exp_writes);
    chk($sformatf("v%0d_done_cnt", e), done_cnt - d0, 1);
    chk($sformatf("v%0d_sb_empty", e), sb_q.size(), 0);
    chk($sformatf("v%0d_count_hold", e), int'(count), vecs[e].exp_count);
    for (int i = 0; i < vecs[e].exp_writes; i++)
      chk($sformatf("v%0d_mem%0d", e, i), int'(mem[i]), int'(exp_byte(e, i)));
    $display("[TB] load %0d: len=%0d gap=%0d writes=%0d count=%0d done_at=N+%0d",
             e, vecs[e].len, vecs[e].gap, wr_cnt - w0, count, t);
  endtask

  initial begin
    int t, w0, d0;
    vecs[0] = '{len: 16, gap: 0, base: 8'h00, pat: 1'b0, exp_writes: 16, exp_count: 16, exp_done: 33};
    vecs[1] = '{len: 3,  gap: 4, base: 8'h00, pat: 1'b1, exp_writes: 3,  exp_count: 3,  exp_done: 13};
    vecs[2] = '{len: 20, gap: 0, base: 8'h40, pat: 1'b0, exp_writes: 16, exp_count: 16, exp_done: 33};
    vecs[3] = '{len: 0,  gap: 0, base: 8'h00, pat: 1'b0, exp_writes: 0,  exp_count: 0,  exp_done: 1};
    vecs[4] = '{len: 1,  gap: 2, base: 8'h30, pat: 1'b0, exp_writes: 1,  exp_count: 1,  exp_done: 3};
    vecs[5] = '{len: 5,  gap: 1, base: 8'h80, pat: 1'b0, exp_writes: 5,  exp_count: 5,  exp_done: 11};
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;

    // Reset held two cycles with start and in_valid asserted.
    reset = 1'b0; start = 1'b1; len = 5'd5; in_valid = 1'b1; in_data = 8'h77;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk("rst_busy", int'(busy), 0);
      chk("rst_hold", int'(cpu_hold), 0);
      chk("rst_ready", int'(in_ready), 0);
      chk("rst_we", int'(ram_we), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_addr", int'(ram_addr), 0);
      chk("rst_data", int'(ram_data), 0);
      chk("rst_count", int'(count), 0);
    end
    reset = 1'b1; start = 1'b0;
    tick();
    chk("rel_ready", int'(in_ready), 0);
    chk("rel_busy", int'(busy), 0);
    in_valid = 1'b0;
    tick();
    $display("[TB] reset sequence done");

    for (int e = 0; e < 6; e++) run_load(e);

    // Reset after three writes of an 8-byte load.
    w0 = wr_cnt; d0 = done_cnt;
    acc_base = acc_total;
    len = 5'd8; start = 1'b1;
    tick();
    start = 1'b0;
    t = 0;
    while (wr_cnt - w0 < 3 && t < 100) begin
      in_data = 8'hC0 + 8'(acc_total - acc_base);
      in_valid = 1'b1;
      tick();
      t++;
    end
    reset = 1'b0;
    tick();
    reset = 1'b1; in_valid = 1'b0;
    chk("mid_rst_hold", int'(cpu_hold), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_addr", int'(ram_addr), 0);
    chk("mid_rst_we", int'(ram_we), 0);
    for (int c = 0; c < 3; c++) tick();
    chk("mid_rst_writes", wr_cnt - w0, 3);
    chk("mid_rst_no_done", done_cnt - d0, 0);
    chk("mid_rst_sb_empty", sb_q.size(), 0);
    for (int i = 0; i < 3; i++) chk($sformatf("mid_rst_mem%0d", i), int'(mem[i]), 32'hC0 + i);
    $display("[TB] reset mid-load: writes=%0d count=%0d", wr_cnt - w0, count);

    // start pulsed in WAIT and again during DONE must not restart.
    w0 = wr_cnt; d0 = done_cnt;
    acc_base = acc_total;
    len = 5'd2; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    len = 5'd9; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_wait_ready", int'(in_ready), 1);
    chk("ign_wait_busy", int'(busy), 1);
    t = 0;
    while (done !== 1'b1 && t < 100) begin
      in_data = 8'h11 + 8'(acc_total - acc_base);
      in_valid = 1'b1;
      tick();
      t++;
    end
    in_valid = 1'b0;
    chk("ign_done_seen", int'(done), 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_done_busy", int'(busy), 0);
    tick();
    chk("ign_idle_busy", int'(busy), 0);
    chk("ign_count", int'(count), 2);
    chk("ign_writes", wr_cnt - w0, 2);
    chk("ign_done_cnt", done_cnt - d0, 1);
    $display("[TB] ignored start: writes=%0d count=%0d", wr_cnt - w0, count);

    // in_valid asserted while idle is not consumed.
    w0 = wr_cnt;
    in_valid = 1'b1; in_data = 8'hEE;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("idle_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    tick();
    chk("idle_writes", wr_cnt - w0, 0);
    chk("idle_sb_empty", sb_q.size(), 0);
    chk("idle_count_hold", int'(count), 2);
    $display("[TB] idle valid: writes=%0d", wr_cnt - w0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sap_ram_loader.md
# sap_ram_loader

Program loader for the SAP RAM: the write-side counterpart to the CPU's fetch/read path. It accepts a byte stream over a valid/ready handshake and writes the bytes to consecutive RAM addresses starting at 0. While loading, it holds the CPU off the bus. It sits between the host-facing byte receiver and the RAM write port, and it owns the RAM only while its `cpu_hold` output is high.

## Interface
- `ADDR_W`, default 4: RAM address width; depth is 2^ADDR_W (16 for SAP-1).
- `DATA_W`, default 8: RAM word and stream byte width.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low; sampled on the rising edge of `clk`.
- `start`  in  1  single-cycle request to begin a load; honoured only in IDLE.
- `len`  in  ADDR_W+1  number of bytes to load; sampled when `start` is accepted.
- `in_data`  in  DATA_W  stream byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader will accept a byte this cycle.
- `ram_addr`  out  ADDR_W  RAM write address.
- `ram_data`  out  DATA_W  RAM write data.
- `ram_we`  out  1  RAM write strobe; the RAM writes on the same rising edge.
- `cpu_hold`  out  1  CPU halted and off the bus.
- `busy`  out  1  load in progress.
- `done`  out  1  one-cycle pulse at the end of a load.
- `count`  out  ADDR_W+1  bytes written in the current or last load.

## Operation
- Moore FSM with states IDLE, WAIT, WRITE, DONE. All outputs decode from registered state only; there are no combinational input-to-output paths.
- **IDLE**
  - On `start`=1, latch `len_q` = min(`len`, 2^ADDR_W), clear the address register and `count`.
  - Go to WAIT if the clamped length is nonzero; otherwise go to DONE.
- **WAIT**
  - `in_ready`=1.
  - When `in_valid`=1 on an edge, capture `in_data` into `data_q` and go to WRITE.
  - Otherwise stay in WAIT, with no timeout.
- **WRITE**
  - `ram_we`=1, `ram_addr`=address register, `ram_data`=`data_q`.
  - At the edge, increment the address and `count`.
  - Go to DONE if the new `count` equals `len_q`; otherwise go to WAIT.
- **DONE**
  - `done`=1 for exactly one cycle, then go to IDLE.
- `cpu_hold`=1 and `busy`=1 in WAIT, WRITE and DONE; both are 0 in IDLE.
- `in_ready`=0 in every state except WAIT. Bytes presented outside WAIT are not consumed.
- `start` is ignored outside IDLE.
- `ram_addr` and `ram_data` hold their last values when `ram_we`=0. They are 0 after reset.
- Address arithmetic is ADDR_W bits. Because of the clamp, the address never wraps within a load.
- `count` is ADDR_W+1 bits, so a full-depth load reads 2^ADDR_W.
- `count` holds its value after DONE until the next accepted `start`.

## Timing
- **Reset** (`reset`=0 at an edge, in any state, including mid-load):
  - Next state is IDLE.
  - `in_ready`, `ram_we`, `cpu_hold`, `busy` and `done` are 0.
  - `ram_addr`, `ram_data` and `count` are 0.
  - RAM words already written are not reverted, and no partial `done` is issued.
- **Start:** if `start` is accepted at edge N, `cpu_hold`, `busy` and `in_ready` are 1 from cycle N+1.
- **Per byte:** a byte accepted at edge M is written at edge M+1 (`ram_we` high during cycle M+1). `in_ready` returns at cycle M+2.
- **Throughput:** at most one byte per 2 cycles.
- **Completion:** for a load of L≥1 bytes with `in_valid` held high, the last write edge is N+2L. `done` is high during cycle N+2L+1, and `cpu_hold` falls at cycle N+2L+2.
- **len=0:** `done` is high during cycle N+1 with zero writes; `cpu_hold` is high for that cycle only.
- **Simultaneous events:**
  - `start`=1 while DONE → ignored; a new `start` is needed once in IDLE.
  - `reset`=0 together with `start` or `in_valid` → reset wins.

## Test plan
- Reset to idle: `reset`=0 for 2 cycles with `start`=1 → all outputs 0, and `in_ready`=0 on the first cycle after release.
- Full load: `len`=16, stream 0x00..0x0F with `in_valid` always high → 16 `ram_we` pulses at addresses 0..15 with data equal to the address; `done` at cycle N+33; `count`=16; `cpu_hold` high from N+1 to N+33.
- Backpressure: `len`=3, bytes 0xA5, 0x5A, 0xFF with `in_valid` dropped for 4 cycles between bytes → RAM[0..2]=A5,5A,FF; no extra writes; `in_ready` stays high while waiting.
- Clamp and zero length:
  - `len`=20 → exactly 16 writes, `count`=16.
  - `len`=0 → no `ram_we`, `done` one cycle after `start`, `count`=0.
- Reset mid-load: `len`=8, `reset`=0 after 3 writes → IDLE next cycle, `cpu_hold`=0, `count`=0, RAM[0..2] retain their data, no `done`.
- Ignored inputs:
  - `start` pulsed during WAIT and during DONE → no restart.
  - `in_valid` asserted in IDLE → `in_ready`=0 and no write.
